// File: rtl/pe_pkg.sv
// Shared types for the processing-element array and its edge feeders.
package pe_pkg;

    localparam int DATA_WIDTH = 8;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } matrix_data_t;

    typedef enum logic [1:0] {
        IDLE,
        SKEW,
        STREAM,
        DONE
    } feeder_state_t;

endpackage

// File: rtl/matrix_feeder.sv
// Buffers one operand vector and streams it into one PE-array edge lane,
// one element per cycle, after SKEW idle cycles of systolic delay.
module matrix_feeder
    import pe_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SKEW  = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         load_valid_i,
    input  logic [DATA_WIDTH-1:0]        load_data_i,
    output logic                         load_ready_o,
    input  logic                         start_i,
    input  logic [$clog2(DEPTH+1)-1:0]   len_i,
    input  logic                         stall_i,
    output matrix_data_t                 out_o,
    output logic                         out_valid_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int LEN_W    = $clog2(DEPTH + 1);
    localparam int IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BUF_N    = 1 << IDX_W;
    localparam int SKW_W    = (SKEW > 0) ? $clog2(SKEW + 1) : 1;
    localparam int SKW_LAST = (SKEW > 0) ? SKEW - 1 : 0;

    feeder_state_t          r_state;
    feeder_state_t          w_state_nxt;
    logic [DATA_WIDTH-1:0]  r_buf [BUF_N];
    logic [LEN_W-1:0]       r_fill;
    logic [LEN_W-1:0]       r_rd_ptr;
    logic [LEN_W-1:0]       r_len;
    logic [SKW_W-1:0]       r_skew_cnt;

    logic                   w_load_fire;
    logic                   w_start_ok;
    logic                   w_issue;
    logic                   w_last_issue;
    logic                   w_skew_end;
    matrix_data_t           w_elem;

    assign load_ready_o = (r_state == pe_pkg::IDLE) && (r_fill < LEN_W'(DEPTH));
    assign busy_o       = (r_state != pe_pkg::IDLE);
    assign w_load_fire  = load_valid_i && load_ready_o;
    // Start is judged against the fill before any same-cycle load lands.
    assign w_start_ok   = start_i && (r_state == pe_pkg::IDLE) &&
                          (len_i != '0) && (len_i <= r_fill);
    assign w_issue      = (r_state == pe_pkg::STREAM) && !stall_i;
    assign w_last_issue = w_issue && (r_rd_ptr == r_len - LEN_W'(1));
    assign w_skew_end   = (r_skew_cnt == SKW_W'(SKW_LAST));

    always_comb begin
        w_elem      = '0;
        w_elem.data = r_buf[r_rd_ptr[IDX_W-1:0]];
        w_elem.last = w_last_issue;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            pe_pkg::IDLE: begin
                if (w_start_ok) begin
                    w_state_nxt = (SKEW > 0) ? pe_pkg::SKEW : pe_pkg::STREAM;
                end
            end
            pe_pkg::SKEW: begin
                if (w_skew_end) begin
                    w_state_nxt = pe_pkg::STREAM;
                end
            end
            pe_pkg::STREAM: begin
                if (w_last_issue) begin
                    w_state_nxt = pe_pkg::DONE;
                end
            end
            pe_pkg::DONE: begin
                w_state_nxt = pe_pkg::IDLE;
            end
            default: begin
                w_state_nxt = pe_pkg::IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= pe_pkg::IDLE;
            r_fill      <= '0;
            r_rd_ptr    <= '0;
            r_skew_cnt  <= '0;
            out_o       <= '0;
            out_valid_o <= 1'b0;
            done_o      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;

            if (w_load_fire) begin
                r_fill <= r_fill + LEN_W'(1);
            end else if (r_state == pe_pkg::DONE) begin
                r_fill <= '0;
            end

            if (w_start_ok || (r_state == pe_pkg::DONE)) begin
                r_rd_ptr <= '0;
            end else if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + LEN_W'(1);
            end

            // Skew count runs regardless of stall; it only delays the first issue.
            if ((r_state == pe_pkg::SKEW) && !w_skew_end) begin
                r_skew_cnt <= r_skew_cnt + SKW_W'(1);
            end else begin
                r_skew_cnt <= '0;
            end

            out_valid_o <= w_issue;
            out_o       <= w_issue ? w_elem : '0;
            done_o      <= (r_state == pe_pkg::DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (w_start_ok) begin
            r_len <= len_i;
        end
        if (w_load_fire) begin
            r_buf[r_fill[IDX_W-1:0]] <= load_data_i;
        end
    end

endmodule

// File: tb/tb_matrix_feeder.sv
// Drives two feeder lanes (SKEW=0 and SKEW=2) with shared stimulus and
// compares every output each cycle against a per-lane behavioural model.
module tb_matrix_feeder;
    import pe_pkg::*;

    localparam int DEPTH = 4;

    logic                  clk;
    logic                  rst;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  start;
    logic [2:0]            len;
    logic                  stall;

    logic                  rdy0, rdy2, ov0, ov2, busy0, busy2, done0, done2;
    matrix_data_t          out0, out2;

    matrix_feeder #(.DEPTH(DEPTH), .SKEW(0)) u_lane0 (
        .clk(clk), .rst(rst), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(rdy0), .start_i(start), .len_i(len), .stall_i(stall),
        .out_o(out0), .out_valid_o(ov0), .busy_o(busy0), .done_o(done0)
    );

    matrix_feeder #(.DEPTH(DEPTH), .SKEW(2)) u_lane2 (
        .clk(clk), .rst(rst), .load_valid_i(load_valid), .load_data_i(load_data),
        .load_ready_o(rdy2), .start_i(start), .len_i(len), .stall_i(stall),
        .out_o(out2), .out_valid_o(ov2), .busy_o(busy2), .done_o(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model, one entry per lane.
    int                    m_skew_cfg [2] = '{0, 2};
    bit                    m_act  [2];
    int                    m_skl  [2];
    int                    m_idx  [2];
    int                    m_len  [2];
    int                    m_fill [2];
    logic [DATA_WIDTH-1:0] m_mem  [2][DEPTH];
    bit                    e_valid [2];
    bit                    e_last  [2];
    bit                    e_done  [2];
    logic [DATA_WIDTH-1:0] e_data  [2];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input int k);
        bit st;
        e_valid[k] = 0;
        e_data[k]  = '0;
        e_last[k]  = 0;
        e_done[k]  = 0;
        if (rst) begin
            m_act[k]  = 0;
            m_fill[k] = 0;
        end else if (m_act[k]) begin
            if (m_skl[k] > 0) begin
                m_skl[k]--;
            end else if (m_idx[k] < m_len[k]) begin
                if (!stall) begin
                    e_valid[k] = 1;
                    e_data[k]  = m_mem[k][m_idx[k]];
                    e_last[k]  = (m_idx[k] == m_len[k] - 1);
                    m_idx[k]++;
                end
            end else begin
                e_done[k] = 1;
                m_fill[k] = 0;
                m_act[k]  = 0;
            end
        end else begin
            st = start && (int'(len) >= 1) && (int'(len) <= m_fill[k]);
            if (load_valid && m_fill[k] < DEPTH) begin
                m_mem[k][m_fill[k]] = load_data;
                m_fill[k]++;
            end
            if (st) begin
                m_act[k] = 1;
                m_skl[k] = m_skew_cfg[k];
                m_idx[k] = 0;
                m_len[k] = int'(len);
            end
        end
    endtask

    task automatic check_lane(input int k, input matrix_data_t o, input logic ov,
                              input logic busy, input logic done, input logic rdy);
        chk_eq($sformatf("lane%0d out_valid", k), 32'(ov), 32'(e_valid[k]));
        chk_eq($sformatf("lane%0d data", k), 32'(o.data), 32'(e_data[k]));
        chk_eq($sformatf("lane%0d last", k), 32'(o.last), 32'(e_last[k]));
        chk_eq($sformatf("lane%0d done", k), 32'(done), 32'(e_done[k]));
        chk_eq($sformatf("lane%0d busy", k), 32'(busy), 32'(m_act[k]));
        chk_eq($sformatf("lane%0d load_ready", k), 32'(rdy),
               32'(!m_act[k] && (m_fill[k] < DEPTH)));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step(0);
        model_step(1);
        @(negedge clk);
        check_lane(0, out0, ov0, busy0, done0, rdy0);
        check_lane(1, out2, ov2, busy2, done2, rdy2);
    endtask

    task automatic do_load(input logic [DATA_WIDTH-1:0] d);
        load_valid = 1'b1;
        load_data  = d;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start(input logic [2:0] l);
        start = 1'b1;
        len   = l;
        tick();
        start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_act[k] = 0; m_skl[k] = 0; m_idx[k] = 0; m_len[k] = 0; m_fill[k] = 0;
            for (int j = 0; j < DEPTH; j++) m_mem[k][j] = '0;
        end
        rst = 1'b1; load_valid = 1'b0; load_data = '0;
        start = 1'b0; len = '0; stall = 1'b0;
        @(negedge clk);
        idle(2);
        rst = 1'b0;

        // Basic stream 3,5,7
        do_load(8'd3); do_load(8'd5); do_load(8'd7);
        do_start(3'd3);
        idle(7);

        // Stall on the cycle element 5 would issue in the unskewed lane
        do_load(8'd3); do_load(8'd5); do_load(8'd7);
        do_start(3'd3);
        tick();
        stall = 1'b1; tick(); stall = 1'b0;
        idle(8);

        // Illegal lengths are ignored, then fill to DEPTH and overflow
        do_load(8'd3); do_load(8'd5); do_load(8'd7);
        do_start(3'd0);
        do_start(3'd4);
        do_load(8'd9);
        do_load(8'd11);
        do_start(3'd4);
        idle(9);

        // Same-cycle load and start: start judged on pre-load fill
        do_load(8'h21); do_load(8'h22);
        load_valid = 1'b1; load_data = 8'h23; start = 1'b1; len = 3'd3;
        tick();
        load_valid = 1'b0; start = 1'b0;
        idle(2);
        do_start(3'd3);
        idle(8);

        // Reset mid-stream
        do_load(8'd1); do_load(8'd2); do_load(8'd3);
        do_start(3'd3);
        idle(3);
        rst = 1'b1; tick(); rst = 1'b0;
        idle(2);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            rst        = ($urandom_range(0, 299) == 0);
            load_valid = $urandom_range(0, 1) == 1;
            load_data  = DATA_WIDTH'($urandom);
            start      = ($urandom_range(0, 3) == 0);
            len        = 3'($urandom_range(0, 7));
            stall      = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
